// File: rtl/pitch_bin_to_hz_if.sv
// Valid/ready data stream used for the peak-bin input and the Hz output.
// The master drives valid/data, the slave drives ready.
interface pitch_bin_to_hz_if #(
    parameter int N = 16
);
    logic         valid;
    logic         ready;
    logic [N-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pitch_bin_to_hz.sv
// Converts FFT peak-bin indices to a median-of-3 filtered pitch in Hz
// (unsigned fixed point), with a sequential shift-add multiplier and a stability flag.
module pitch_bin_to_hz #(
    parameter int W        = 16,
    parameter int NSamples = 1024,
    parameter int FS_HZ    = 12000,
    parameter int HZ_FRAC  = 4,
    parameter int MIN_BIN  = 2,
    parameter int STABLE_N = 3
) (
    input  logic               clk,
    input  logic               reset,
    pitch_bin_to_hz_if.slave   pitch_input,
    pitch_bin_to_hz_if.master  hz_output,
    output logic               pitch_stable
);
    localparam int     SHIFT = $clog2(NSamples);
    localparam longint K_L   = longint'(FS_HZ) * (longint'(1) << HZ_FRAC);
    localparam int     KW    = $clog2(K_L + 1);
    localparam int     AW    = W + KW;
    localparam int     CW    = (W > 1) ? $clog2(W) : 1;
    localparam int     SCW   = $clog2(STABLE_N + 1);
    localparam logic [AW-1:0] K_VAL = AW'(K_L);

    typedef enum logic [1:0] {IDLE, MED, MUL, OUT} state_t;
    state_t state, state_nxt;

    logic [W-1:0]   w0, w1, w2;
    logic [1:0]     fill;
    logic [W-1:0]   med_q, prev_m;
    logic [W-1:0]   m_sh;
    logic [AW-1:0]  k_sh, acc;
    logic [CW-1:0]  cnt;
    logic [SCW-1:0] st_cnt, st_cnt_nxt;
    logic [W-1:0]   k_in, med_w;
    logic [AW-1:0]  res;
    logic           accept, out_xfer;

    function automatic logic [W-1:0] med3(input logic [W-1:0] a, b, c);
        logic [W-1:0] lo, hi, mid;
        lo  = (a < b) ? a : b;
        hi  = (a < b) ? b : a;
        mid = (hi < c) ? hi : c;
        return (lo > mid) ? lo : mid;
    endfunction

    assign pitch_input.ready = (state == IDLE) && !reset;
    assign accept   = pitch_input.valid && pitch_input.ready;
    assign out_xfer = (state == OUT) && hz_output.valid && hz_output.ready;
    assign k_in     = (pitch_input.data < W'(MIN_BIN)) ? '0 : pitch_input.data;
    assign med_w    = (fill == 2'd3) ? med3(w0, w1, w2) : w0;
    assign res      = acc >> SHIFT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = MED;
            MED:  state_nxt = MUL;
            MUL:  if (cnt == CW'(W - 1)) state_nxt = OUT;
            OUT:  if (out_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Zero medians mean "no pitch" and never count toward stability.
    always_comb begin
        st_cnt_nxt = st_cnt;
        if (med_q == prev_m && med_q != '0)
            st_cnt_nxt = (st_cnt == SCW'(STABLE_N)) ? st_cnt : st_cnt + 1'b1;
        else
            st_cnt_nxt = (med_q == '0) ? '0 : SCW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w0              <= '0;
            w1              <= '0;
            w2              <= '0;
            fill            <= '0;
            med_q           <= '0;
            prev_m          <= '0;
            m_sh            <= '0;
            k_sh            <= '0;
            acc             <= '0;
            cnt             <= '0;
            st_cnt          <= '0;
            pitch_stable    <= 1'b0;
            hz_output.valid <= 1'b0;
            hz_output.data  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    w2   <= w1;
                    w1   <= w0;
                    w0   <= k_in;
                    fill <= (fill == 2'd3) ? 2'd3 : fill + 2'd1;
                end
                MED: begin
                    med_q <= med_w;
                    m_sh  <= med_w;
                    k_sh  <= K_VAL;
                    acc   <= '0;
                    cnt   <= '0;
                end
                MUL: begin
                    if (m_sh[0]) acc <= acc + k_sh;
                    m_sh <= m_sh >> 1;
                    k_sh <= k_sh << 1;
                    cnt  <= cnt + 1'b1;
                end
                OUT: begin
                    // First OUT cycle registers the saturated result; it then holds until taken.
                    if (!hz_output.valid) begin
                        hz_output.valid <= 1'b1;
                        hz_output.data  <= (|res[AW-1:W]) ? '1 : res[W-1:0];
                    end else if (hz_output.ready) begin
                        hz_output.valid <= 1'b0;
                        prev_m          <= med_q;
                        st_cnt          <= st_cnt_nxt;
                        pitch_stable    <= (st_cnt_nxt == SCW'(STABLE_N));
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
